// File: rtl/spi_master_v2_clkdiv_pkg.sv
// Shared definitions for the divided-clock SPI master: FSM encoding and chip-select helpers.
package spi_master_v2_clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LOAD     = 2'b01,
        TRANSFER = 2'b10,
        DONE     = 2'b11
    } state_t;

    localparam logic [3:0] CS_IDLE = 4'b1111;

    // Active-low one-hot select for the addressed slave.
    function automatic logic [3:0] cs_decode(input logic [1:0] sel);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << sel;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/spi_master_v2_clkdiv_clk_divider.sv
// SCLK generator: CLK_DIV system clocks per half-period, with one-cycle strobes that coincide
// with the clock edge on which sclk toggles.
module spi_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    always_comb begin
        tc     = en && (cnt_q == TC);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        // Disabled means parked: counter cleared and sclk low, so every byte starts with a full low phase.
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = tc && !sclk_q;
    assign fall = tc && sclk_q;

endmodule

// File: rtl/spi_master_v2_clkdiv.sv
// Mode-0 SPI burst master: 1..15 bytes to one of four slaves, CS held for the whole burst,
// next byte fetched from data_in in a single LOAD cycle between bytes.
module spi_master_v2_clkdiv
    import spi_master_v2_clkdiv_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [3:0] data_len,
    input  logic [1:0] cs_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [3:0] cs_n
);

    state_t     state, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] byte_q, byte_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_rise, sclk_fall;

    spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == TRANSFER),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_comb begin
        state_d = state;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_d    = data_in;
                    sel_d   = cs_sel;
                    byte_d  = (data_len == 4'd0) ? 4'd1 : data_len;
                    bit_d   = 3'd0;
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (sclk_rise) rx_d = {rx_q[6:0], miso};
                // The 8th rise has already landed in rx_q when the 8th fall arrives.
                if (sclk_fall) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        dout_d  = rx_q;
                        byte_d  = byte_q - 4'd1;
                        state_d = (byte_q == 4'd1) ? DONE : LOAD;
                    end
                end
            end
            LOAD: begin
                tx_d    = data_in;
                state_d = TRANSFER;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tx_q   <= '0;
            rx_q   <= '0;
            dout_q <= '0;
            sel_q  <= '0;
            byte_q <= '0;
            bit_q  <= '0;
        end else begin
            state  <= state_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            dout_q <= dout_d;
            sel_q  <= sel_d;
            byte_q <= byte_d;
            bit_q  <= bit_d;
        end
    end

    // tx_q is fully shifted out by the end of each byte, so mosi naturally rests low outside a burst.
    assign mosi     = tx_q[7];
    assign busy     = (state == LOAD) || (state == TRANSFER);
    assign done     = (state == DONE);
    assign cs_n     = busy ? cs_decode(sel_q) : CS_IDLE;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master_v2_clkdiv.sv
// Directed + randomized bench for spi_master_v2_clkdiv with a bit-level reference model.
module tb_spi_master_v2_clkdiv;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] data_len = '0;
    logic [1:0] cs_sel = '0;
    logic       busy, done, sclk, mosi, miso;
    logic [7:0] data_out;
    logic [3:0] cs_n;

    int         miso_mode = 0;   // 0 random, 1 loopback, 2 tied high
    logic       miso_r = 1'b0;
    logic [7:0] bytes [16];
    logic [7:0] last_rx;
    int         passed = 0;
    int         total = 0;
    int         fails = 0;

    assign miso = (miso_mode == 1) ? mosi : (miso_mode == 2) ? 1'b1 : miso_r;

    always #5 clk = ~clk;

    spi_master_v2_clkdiv #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .data_len(data_len),
        .cs_sel(cs_sel), .busy(busy), .done(done), .data_out(data_out), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cs_n"}, cs_n, 4'hF);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_mosi"}, mosi, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dout"}, data_out, 8'h00);
        chk({tag, "_state"}, dut.state, 2'b00);
    endtask

    // Runs one burst from bytes[], checking every cycle against the protocol rules.
    task automatic run_burst(input string tag, input logic [3:0] len, input logic [1:0] sel,
                             input bit mid_start);
        int         n = (len == 0) ? 1 : int'(len);
        logic [3:0] exp_cs = ~(4'b0001 << sel);
        int         loads = 0, rises = 0, tcyc = 0, dones = 0, runlen = 0;
        int         bytei = 0, nbits = 0, cyc = 0, after_done = 0;
        logic [7:0] mob = '0, rxb = '0, exp_last = '0;
        logic       prev_s = 1'b0, prev_mosi = 1'b0;
        bit         cs_ok = 1, sclk_ok = 1, stab_ok = 1, hilo_ok = 1, mosi_ok = 1;
        bit         dout_ok = 1, busy_ok = 1;
        logic [1:0] st;

        @(negedge clk);
        data_in  = bytes[0];
        data_len = len;
        cs_sel   = sel;
        start    = 1'b1;
        for (cyc = 0; cyc < 4000 && after_done < 2; cyc++) begin
            @(negedge clk);
            start    = (mid_start && cyc == 40);
            cs_sel   = 2'($urandom);
            data_len = 4'($urandom);
            st = dut.state;
            if (st == 2'b10 || st == 2'b01) begin
                if (cs_n !== exp_cs) cs_ok = 0;
                if (busy !== 1'b1) busy_ok = 0;
            end else begin
                if (cs_n !== 4'hF) cs_ok = 0;
                if (busy !== 1'b0) busy_ok = 0;
            end
            if (st != 2'b10 && sclk !== 1'b0) sclk_ok = 0;
            if (st == 2'b10) begin
                tcyc++;
                if (sclk !== prev_s) begin
                    if (runlen != CLK_DIV) hilo_ok = 0;
                    runlen = 1;
                end else runlen++;
                if (sclk && !prev_s) begin
                    rises++;
                    if (mosi !== prev_mosi) stab_ok = 0;
                    mob = {mob[6:0], mosi};
                    rxb = {rxb[6:0], (miso_mode == 1) ? mosi : (miso_mode == 2) ? 1'b1 : miso_r};
                    nbits++;
                    if (nbits == 8) begin
                        if (mob !== bytes[bytei]) mosi_ok = 0;
                        exp_last = rxb;
                        nbits = 0;
                        bytei++;
                    end
                end
                prev_s = sclk;
            end else begin
                if (runlen != 0 && runlen != CLK_DIV) hilo_ok = 0;
                runlen = 0;
                prev_s = 1'b0;
            end
            if (st == 2'b01) begin
                loads++;
                if (data_out !== exp_last) dout_ok = 0;
                data_in = bytes[bytei];
            end
            if (done) begin
                dones++;
                if (data_out !== exp_last || st != 2'b11) dout_ok = 0;
            end
            if (dones > 0) after_done++;
            prev_mosi = mosi;
            if (miso_mode == 0) miso_r = 1'($urandom);
        end
        start = 1'b0;
        last_rx = exp_last;
        chk({tag, "_timeout"}, (cyc < 4000), 1);
        chk({tag, "_cs_n"}, cs_ok, 1);
        chk({tag, "_busy"}, busy_ok, 1);
        chk({tag, "_sclk_idle"}, sclk_ok, 1);
        chk({tag, "_mosi_stable"}, stab_ok, 1);
        chk({tag, "_sclk_halfper"}, hilo_ok, 1);
        chk({tag, "_mosi_bits"}, mosi_ok, 1);
        chk({tag, "_data_out"}, dout_ok, 1);
        chk({tag, "_loads"}, loads, n - 1);
        chk({tag, "_rises"}, rises, 8 * n);
        chk({tag, "_xfer_cycles"}, tcyc, 16 * CLK_DIV * n);
        chk({tag, "_done_pulses"}, dones, 1);
    endtask

    initial begin
        #1;
        chk_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 3-byte burst to slave 1 with miso tied high
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h7E;
        miso_mode = 2;
        run_burst("burst3", 4'd3, 2'd1, 1'b0);
        chk("burst3_dout_ff", data_out, 8'hFF);

        // single-byte loopback to slave 3
        bytes[0] = 8'h5A;
        miso_mode = 1;
        run_burst("loopback", 4'd1, 2'd3, 1'b0);
        chk("loopback_dout", data_out, 8'h5A);

        // length 0 means one byte
        miso_mode = 0;
        bytes[0] = 8'($urandom);
        run_burst("len0", 4'd0, 2'd2, 1'b0);

        // start pulsed mid-burst must be ignored
        bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
        run_burst("midstart", 4'd2, 2'd0, 1'b1);

        // reset in the middle of a byte
        bytes[0] = 8'hC3; bytes[1] = 8'h81;
        @(negedge clk);
        data_in = bytes[0]; data_len = 4'd2; cs_sel = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset_idle_done", done, 0);
        chk("midreset_idle_state", dut.state, 2'b00);

        run_burst("postreset", 4'd2, 2'd2, 1'b0);
        chk("postreset_dout", data_out, last_rx);

        // randomized bursts
        for (int k = 0; k < 4; k++) begin
            logic [3:0] len;
            len = 4'($urandom_range(0, 6));
            for (int b = 0; b < 16; b++) bytes[b] = 8'($urandom);
            run_burst($sformatf("rand%0d", k), len, 2'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
